// File: rtl/systolic_feeder.sv
// Operand feeder for the systolic array: holds A/B, skews operand streams.
// FEEDER_TRANSPOSE_B_EN: B words load columns instead of rows.
module systolic_feeder #(
    parameter  int DATA_WIDTH = 16,
    parameter  int BUS_WIDTH  = 64,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int DIM_W      = $clog2(MAX_DIM),
    localparam int OPS_W      = MAX_DIM * DATA_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic                 wr_sel_i,
    input  logic [DIM_W-1:0]     wr_idx_i,
    input  logic [BUS_WIDTH-1:0] wr_data_i,
    input  logic                 go_i,
    input  logic [DIM_W-1:0]     dim_k_i,
    output logic                 start_o,
    output logic [OPS_W-1:0]     left_ops_o,
    output logic [OPS_W-1:0]     up_ops_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CW = DIM_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                       state_q;
    logic [CW-1:0]                t_q;
    logic [CW-1:0]                k_q;
    logic                         start_q;
    logic                         busy_q;
    logic                         done_q;
    logic [OPS_W-1:0]             left_q;
    logic [OPS_W-1:0]             up_q;
    logic signed [DATA_WIDTH-1:0] a_q [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0] b_q [MAX_DIM][MAX_DIM];

    logic [CW-1:0]    feed_last;
    logic [CW-1:0]    ts_d;
    logic [CW-1:0]    diff_d;
    logic [OPS_W-1:0] left_d;
    logic [OPS_W-1:0] up_d;

    assign feed_last = k_q + CW'(MAX_DIM - 2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_en_i && !busy_q) begin
            for (int e = 0; e < MAX_DIM; e++) begin
                if (!wr_sel_i) begin
                    a_q[wr_idx_i][e] <= wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
                end else begin
`ifdef FEEDER_TRANSPOSE_B_EN
                    b_q[e][wr_idx_i] <= wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
`else
                    b_q[wr_idx_i][e] <= wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
`endif
                end
            end
        end
    end

    // Operands for the FEED step that the next edge enters.
    always_comb begin
        ts_d   = (state_q == S_CLEAR) ? '0 : t_q + CW'(1);
        diff_d = '0;
        left_d = '0;
        up_d   = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            diff_d = ts_d - CW'(i);
            if (ts_d >= CW'(i) && diff_d < k_q) begin
                left_d[i*DATA_WIDTH +: DATA_WIDTH] = a_q[i][diff_d[DIM_W-1:0]];
                up_d[i*DATA_WIDTH +: DATA_WIDTH]   = b_q[diff_d[DIM_W-1:0]][i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            k_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= '0;
            up_q    <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= '0;
            up_q    <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (go_i) begin
                        state_q <= S_CLEAR;
                        k_q     <= CW'(dim_k_i) + CW'(1);
                        t_q     <= '0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_FEED;
                    t_q     <= '0;
                    left_q  <= left_d;
                    up_q    <= up_d;
                end
                S_FEED: begin
                    if (t_q == feed_last) begin
                        state_q <= S_DRAIN;
                        t_q     <= '0;
                    end else begin
                        t_q    <= t_q + CW'(1);
                        left_q <= left_d;
                        up_q   <= up_d;
                    end
                end
                S_DRAIN: begin
                    if (t_q == CW'(MAX_DIM - 2)) begin
                        state_q <= S_DONE;
                        t_q     <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        t_q <= t_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    t_q     <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_o    = start_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign left_ops_o = left_q;
    assign up_ops_o   = up_q;

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand transmitter for the systolic multiply array. It holds matrix A (N×K) and matrix B (K×M) loaded one bus word at a time, and clears the PE grid with a one-cycle `start_o` pulse. It then drives the left edge (rows of A) and top edge (columns of B) with diagonally skewed operand streams, zero-padded, and pulses `done_o` on the first cycle in which every PE `res_o` holds its final dot product.

## Interface
- `DATA_WIDTH`, 16, operand width in bits (signed).
- `BUS_WIDTH`, 64, load-bus width in bits.
- `MAX_DIM` (localparam), BUS_WIDTH/DATA_WIDTH, array dimension.
- `DIM_W` (localparam), $clog2(MAX_DIM), width of dimension fields.
- Clock and reset: one clock; reset is asynchronous and active-low, ports `clk_i` / `rst_ni`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `wr_en_i`  in  1  load strobe; writes one word when idle.
- `wr_sel_i`  in  1  0 = A storage, 1 = B storage.
- `wr_idx_i`  in  DIM_W  row of A, or B line (see Configuration).
- `wr_data_i`  in  BUS_WIDTH  element e at bits [e*DATA_WIDTH +: DATA_WIDTH].
- `go_i`  in  1  start multiplication; sampled only in IDLE.
- `dim_k_i`  in  DIM_W  inner dimension K-1; sampled with `go_i`.
- `start_o`  out  1  PE clear pulse; drives every PE `start_i`.
- `left_ops_o`  out  MAX_DIM*DATA_WIDTH  slice i drives `left_operand_i` of PE(i,0).
- `up_ops_o`  out  MAX_DIM*DATA_WIDTH  slice j drives `up_operand_i` of PE(0,j).
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse: results valid.

## Operation
- Storage: A[MAX_DIM][MAX_DIM] and B[MAX_DIM][MAX_DIM], signed DATA_WIDTH registers.
  - A write replaces the whole line `wr_idx_i`.
  - Writes are ignored while `busy_o`=1.
  - Unused rows and columns are loaded with zero by the user. N and M are not tracked; the full MAX_DIM edge is always driven.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE → CLEAR on `go_i`. K is latched from `dim_k_i`+1.
  - CLEAR → FEED after 1 cycle. `start_o`=1 during CLEAR only.
  - FEED lasts K+MAX_DIM-1 cycles, counter t=0…K+MAX_DIM-2.
  - DRAIN lasts MAX_DIM-1 cycles.
  - DONE lasts 1 cycle with `done_o`=1, then → IDLE.
- Skew rule, in FEED cycle t:
  - slice i of `left_ops_o` = A[i][t-i] if 0 ≤ t-i < K, else 0.
  - slice j of `up_ops_o` = B[t-j][j] if 0 ≤ t-j < K, else 0.
- Outside FEED, both operand buses are all-zero.
- All outputs are registered. No combinational path from inputs to outputs.
- Simultaneous `go_i` and `wr_en_i` in IDLE: the write is committed, and the first FEED cycle uses the written data.
- `go_i` while busy is ignored. It is not queued.
- `dim_k_i` changes after `go_i` have no effect until the next `go_i`.

## Timing
- Reset values:
  - `start_o`=0, `busy_o`=0, `done_o`=0.
  - `left_ops_o`=0, `up_ops_o`=0.
  - State IDLE, counter 0, all A/B storage 0.
- Reset asserted mid-operation aborts immediately to these values. The PE grid is reset by the same `rst_ni`.
- Cycle 0 is the cycle with `go_i`=1 in IDLE.
  - Cycle 1: CLEAR, `start_o`=1.
  - Cycle 2 is FEED t=0.
- PE(i,j) sees element k at FEED-relative cycle c=k+i+j. The last product lands at c=K-1+2(MAX_DIM-1).
- `done_o` is high at FEED-relative cycle c=K+2·MAX_DIM-2. At that point every PE `res_o`/`carry_o` is final and stays stable until the next `start_o`.
- Example, MAX_DIM=4 and K=4:
  - FEED occupies cycles 2–8, DRAIN cycles 9–11.
  - `done_o` is high in cycle 12.
  - `busy_o` is high in cycles 1–12.
- Back-to-back: `go_i` in the cycle after DONE (IDLE) is accepted.

## Configuration
- `FEEDER_TRANSPOSE_B_EN` undefined: a B write (`wr_sel_i`=1) loads B row `wr_idx_i`, element e → B[wr_idx_i][e].
- `FEEDER_TRANSPOSE_B_EN` defined: a B write loads B column `wr_idx_i`, element e → B[e][wr_idx_i].
- A is always row-loaded. Skew, timing and outputs are otherwise identical in both builds.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `busy_o`=0. Assert `rst_ni` low during FEED t=3 → outputs 0 and state IDLE within the same cycle; the next `go_i` restarts from CLEAR.
- A=I (4×4 identity), B rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}, K=4 → `start_o` in cycle 1 only, `done_o` in cycle 12 only, connected PE grid `res_o`(i,j) = B[i][j].
- Skew check, same load: at FEED t=0, left slice 0=A[0][0] and slices 1–3=0; at t=3, left slice 3=A[3][0]; at t=6, only slice 3 is nonzero (A[3][3]); in DRAIN, buses are all-zero.
- K=2 (`dim_k_i`=1), A rows {2,-3,0,0}, B rows {4,5,…}, {-1,7,…} → FEED lasts 5 cycles, `done_o` at FEED-relative cycle 8, PE(0,0) `res_o` = 2·4 + (-3)(-1) = 11.
- `wr_en_i` and `go_i` in the same cycle writing A row 0={7,0,0,0} → t=0 left slice 0 = 7. A `wr_en_i` during FEED is ignored, so the next run reproduces the same results. `go_i` during DRAIN is ignored, giving exactly one `done_o`.
- Build with `FEEDER_TRANSPOSE_B_EN`, load B by columns with the transposed values of the second scenario → identical `res_o` grid and identical cycle timing.
